// File: rtl/sdio_pkg.sv
// sdio_pkg: shared types and constants for the SDIO transfer sequencer.
// Holds the sequencer state encoding, the request payload struct and the
// status bit/mask constants used to build the latched completion status.
package sdio_pkg;

    localparam int unsigned CMD_OP_W = 6;
    localparam int unsigned ARG_W    = 32;
    localparam int unsigned RSP_W    = 3;
    localparam int unsigned BSIZE_W  = 10;
    localparam int unsigned BNUM_W   = 8;
    localparam int unsigned STAT_W   = 16;

    typedef enum logic [2:0] {
        SEQ_IDLE     = 3'd0,
        SEQ_SETUP    = 3'd1,
        SEQ_ISSUE    = 3'd2,
        SEQ_WAIT_EOT = 3'd3,
        SEQ_DONE     = 3'd4
    } sdio_seq_state_e;

    // Fully described command/data transfer request
    typedef struct packed {
        logic [CMD_OP_W-1:0] cmd_op;
        logic [ARG_W-1:0]    cmd_arg;
        logic [RSP_W-1:0]    rsp_type;
        logic                data_en;
        logic                data_rwn;
        logic                data_quad;
        logic [BSIZE_W-1:0]  block_size;
        logic [BNUM_W-1:0]   block_num;
    } sdio_req_t;

    localparam int unsigned STAT_TIMEOUT_BIT = 15;
    localparam int unsigned STAT_ABORT_BIT   = 14;

    localparam logic [STAT_W-1:0] CMD_ERR_MASK  = 16'h003F;
    localparam logic [STAT_W-1:0] DATA_ERR_MASK = 16'h3F00;

    localparam logic [STAT_W-1:0] STAT_TIMEOUT_VAL = STAT_W'(1) << STAT_TIMEOUT_BIT;
    localparam logic [STAT_W-1:0] STAT_ABORT_VAL   = STAT_W'(1) << STAT_ABORT_BIT;

endpackage

// File: rtl/sdio_cmd_seq_if.sv
// sdio_cmd_seq_if: request channel from the register file and the
// command/data configuration channel towards the SDIO TX/RX top.
// Signal suffixes are named from the sequencer's point of view.
//   slave  : sequencer side (takes requests, drives TX/RX config)
//   master : environment side (register file + TX/RX)
interface sdio_cmd_seq_if;
    import sdio_pkg::*;

    // request channel
    logic                req_valid_i;
    logic                req_ready_o;
    logic [CMD_OP_W-1:0] req_cmd_op_i;
    logic [ARG_W-1:0]    req_cmd_arg_i;
    logic [RSP_W-1:0]    req_rsp_type_i;
    logic                req_data_en_i;
    logic                req_data_rwn_i;
    logic                req_data_quad_i;
    logic [BSIZE_W-1:0]  req_block_size_i;
    logic [BNUM_W-1:0]   req_block_num_i;

    // TX/RX channel
    logic                cmd_start_o;
    logic [CMD_OP_W-1:0] cmd_op_o;
    logic [ARG_W-1:0]    cmd_arg_o;
    logic [RSP_W-1:0]    cmd_rsp_type_o;
    logic                data_en_o;
    logic                data_rwn_o;
    logic                data_quad_o;
    logic [BSIZE_W-1:0]  data_block_size_o;
    logic [BNUM_W-1:0]   data_block_num_o;
    logic                clr_stat_o;
    logic                eot_i;
    logic [STAT_W-1:0]   status_i;

    modport slave (
        input  req_valid_i, req_cmd_op_i, req_cmd_arg_i, req_rsp_type_i,
               req_data_en_i, req_data_rwn_i, req_data_quad_i,
               req_block_size_i, req_block_num_i, eot_i, status_i,
        output req_ready_o, cmd_start_o, cmd_op_o, cmd_arg_o, cmd_rsp_type_o,
               data_en_o, data_rwn_o, data_quad_o, data_block_size_o,
               data_block_num_o, clr_stat_o
    );

    modport master (
        output req_valid_i, req_cmd_op_i, req_cmd_arg_i, req_rsp_type_i,
               req_data_en_i, req_data_rwn_i, req_data_quad_i,
               req_block_size_i, req_block_num_i, eot_i, status_i,
        input  req_ready_o, cmd_start_o, cmd_op_o, cmd_arg_o, cmd_rsp_type_o,
               data_en_o, data_rwn_o, data_quad_o, data_block_size_o,
               data_block_num_o, clr_stat_o
    );

endinterface

// File: rtl/sdio_req_buf.sv
// sdio_req_buf: one-entry valid/ready holding buffer for sdio_req_t.
// Ports: clk_i/rst_i (sync active-high), push_i/data_i write side,
// pop_i/data_o read side, full_o occupancy, ready_o = slot free (registered).
module sdio_req_buf
    import sdio_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      push_i,
    input  sdio_req_t data_i,
    input  logic      pop_i,
    output sdio_req_t data_o,
    output logic      full_o,
    output logic      ready_o
);

    logic      full_q, full_d;
    sdio_req_t data_q, data_d;

    // Pop frees the slot; a push in the same cycle refills it
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (pop_i) begin
            full_d = 1'b0;
        end
        if (push_i && (!full_q || pop_i)) begin
            full_d = 1'b1;
            data_d = data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign data_o  = data_q;
    assign full_o  = full_q;
    assign ready_o = ~full_q;

endmodule

// File: rtl/sdio_cmd_seq.sv
// sdio_cmd_seq: transfer sequencer upstream of the SDIO TX/RX top.
// Buffers one pending request, applies the data configuration one cycle
// ahead of a single-cycle cmd_start, waits for end-of-transfer (or abort /
// watchdog) and reports a latched status with done/err events.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   bus (slave)           request channel + TX/RX configuration channel
//   abort_i               abort the active transfer
//   timeout_cycles_i      watchdog limit, 0 disables (SDIO_CMD_SEQ_TIMEOUT_EN only)
//   busy_o                a transfer is in flight
//   done_o / err_o        one-cycle completion event / error qualifier
//   status_o              latched final status
// Optional feature: define SDIO_CMD_SEQ_TIMEOUT_EN for the response watchdog.
module sdio_cmd_seq
    import sdio_pkg::*;
#(
    parameter int unsigned TO_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    sdio_cmd_seq_if.slave     bus,
    input  logic              abort_i,
`ifdef SDIO_CMD_SEQ_TIMEOUT_EN
    input  logic [TO_W-1:0]   timeout_cycles_i,
`endif
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [STAT_W-1:0] status_o
);

    localparam logic [2:0] ST_IDLE     = SEQ_IDLE;
    localparam logic [2:0] ST_SETUP    = SEQ_SETUP;
    localparam logic [2:0] ST_ISSUE    = SEQ_ISSUE;
    localparam logic [2:0] ST_WAIT_EOT = SEQ_WAIT_EOT;
    localparam logic [2:0] ST_DONE     = SEQ_DONE;

    logic [2:0]        state_q, state_d;
    sdio_req_t         act_q, act_d;
    logic              data_en_q, data_en_d;
    logic              cmd_start_q, cmd_start_d;
    logic              clr_stat_q, clr_stat_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [STAT_W-1:0] status_q, status_d;

    logic              fin_c;
    logic [STAT_W-1:0] fin_status_c;
    logic              pop_c;
    logic              push_c;
    logic              buf_full_c;
    logic              buf_ready_c;
    sdio_req_t         in_req_c;
    sdio_req_t         buf_req_c;

`ifdef SDIO_CMD_SEQ_TIMEOUT_EN
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              to_hit_c;
    assign to_hit_c = (timeout_cycles_i != '0) && (to_cnt_q == timeout_cycles_i);
`else
    localparam int unsigned unused_to_w = TO_W;
`endif

    assign in_req_c = '{
        cmd_op:     bus.req_cmd_op_i,
        cmd_arg:    bus.req_cmd_arg_i,
        rsp_type:   bus.req_rsp_type_i,
        data_en:    bus.req_data_en_i,
        data_rwn:   bus.req_data_rwn_i,
        data_quad:  bus.req_data_quad_i,
        block_size: bus.req_block_size_i,
        block_num:  bus.req_block_num_i
    };

    assign push_c = bus.req_valid_i & buf_ready_c;

    sdio_req_buf u_req_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_c),
        .data_i  (in_req_c),
        .pop_i   (pop_c),
        .data_o  (buf_req_c),
        .full_o  (buf_full_c),
        .ready_o (buf_ready_c)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        act_d        = act_q;
        data_en_d    = data_en_q;
        cmd_start_d  = 1'b0;
        clr_stat_d   = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;
        status_d     = status_q;
        fin_c        = 1'b0;
        fin_status_c = '0;
        pop_c        = 1'b0;
`ifdef SDIO_CMD_SEQ_TIMEOUT_EN
        to_cnt_d     = to_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (buf_full_c) begin
                    pop_c     = 1'b1;
                    act_d     = buf_req_c;
                    data_en_d = buf_req_c.data_en;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (abort_i) begin
                    fin_c        = 1'b1;
                    fin_status_c = STAT_ABORT_VAL;
                end else begin
                    data_en_d   = act_q.data_en;
                    cmd_start_d = 1'b1;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (abort_i) begin
                    fin_c        = 1'b1;
                    fin_status_c = STAT_ABORT_VAL;
                end else begin
                    state_d = ST_WAIT_EOT;
`ifdef SDIO_CMD_SEQ_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                end
            end
            ST_WAIT_EOT: begin
                // abort beats eot, eot beats the watchdog
                if (abort_i) begin
                    fin_c        = 1'b1;
                    fin_status_c = STAT_ABORT_VAL;
                end else if (bus.eot_i) begin
                    fin_c        = 1'b1;
                    fin_status_c = bus.status_i & ~(STAT_TIMEOUT_VAL | STAT_ABORT_VAL);
                end
`ifdef SDIO_CMD_SEQ_TIMEOUT_EN
                else if (to_hit_c) begin
                    fin_c        = 1'b1;
                    fin_status_c = STAT_TIMEOUT_VAL;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Common completion path into DONE
        if (fin_c) begin
            state_d     = ST_DONE;
            status_d    = fin_status_c;
            done_d      = 1'b1;
            clr_stat_d  = 1'b1;
            data_en_d   = 1'b0;
            cmd_start_d = 1'b0;
            err_d       = (|(fin_status_c & (CMD_ERR_MASK | DATA_ERR_MASK)))
                        | fin_status_c[STAT_TIMEOUT_BIT]
                        | fin_status_c[STAT_ABORT_BIT];
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            act_q       <= '0;
            data_en_q   <= 1'b0;
            cmd_start_q <= 1'b0;
            clr_stat_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            status_q    <= '0;
        end else begin
            state_q     <= state_d;
            act_q       <= act_d;
            data_en_q   <= data_en_d;
            cmd_start_q <= cmd_start_d;
            clr_stat_q  <= clr_stat_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            status_q    <= status_d;
        end
    end

`ifdef SDIO_CMD_SEQ_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`endif

    assign bus.req_ready_o       = buf_ready_c;
    assign bus.cmd_start_o       = cmd_start_q;
    assign bus.cmd_op_o          = act_q.cmd_op;
    assign bus.cmd_arg_o         = act_q.cmd_arg;
    assign bus.cmd_rsp_type_o    = act_q.rsp_type;
    assign bus.data_en_o         = data_en_q;
    assign bus.data_rwn_o        = act_q.data_rwn;
    assign bus.data_quad_o       = act_q.data_quad;
    assign bus.data_block_size_o = act_q.block_size;
    assign bus.data_block_num_o  = act_q.block_num;
    assign bus.clr_stat_o        = clr_stat_q;

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign err_o    = err_q;
    assign status_o = status_q;

endmodule

// File: tb/tb_sdio_cmd_seq.sv
// tb_sdio_cmd_seq: self-checking bench for sdio_cmd_seq.
// A transaction-level model (pending queue + age of the active transfer)
// predicts every output each cycle; directed scenarios pin key latencies
// with literal values, then a randomized phase stresses the sequencer.
module tb_sdio_cmd_seq;
    import sdio_pkg::*;

    localparam int unsigned TO_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              abort;
    logic              busy, done, err;
    logic [STAT_W-1:0] status;
`ifdef SDIO_CMD_SEQ_TIMEOUT_EN
    logic [TO_W-1:0]   tmo;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    sdio_cmd_seq_if bus();

    sdio_cmd_seq #(.TO_W(TO_W)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .bus              (bus),
        .abort_i          (abort),
`ifdef SDIO_CMD_SEQ_TIMEOUT_EN
        .timeout_cycles_i (tmo),
`endif
        .busy_o           (busy),
        .done_o           (done),
        .err_o            (err),
        .status_o         (status)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input longint unsigned act,
                                input longint unsigned exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endfunction

    // ---------------- behavioural model ----------------
    sdio_req_t   pend[$];
    sdio_req_t   act_m = '0;
    bit          m_active = 1'b0;
    int          age = 0;       // 0: config applied, 1: start pulse, >=2: waiting
    bit          e_ready = 1'b1, e_busy = 1'b0, e_start = 1'b0, e_den = 1'b0;
    bit          e_done = 1'b0, e_err = 1'b0, e_clr = 1'b0;
    logic [15:0] e_status = '0;

    always @(posedge clk) begin : model
        sdio_req_t   cur;
        bit          push;
        bit          ended;
        logic [15:0] fin;
        int          tlim;
        cyc++;
        cur = '{cmd_op: bus.req_cmd_op_i, cmd_arg: bus.req_cmd_arg_i,
                rsp_type: bus.req_rsp_type_i, data_en: bus.req_data_en_i,
                data_rwn: bus.req_data_rwn_i, data_quad: bus.req_data_quad_i,
                block_size: bus.req_block_size_i, block_num: bus.req_block_num_i};
        tlim = 0;
`ifdef SDIO_CMD_SEQ_TIMEOUT_EN
        tlim = int'(tmo);
`endif
        if (rst) begin
            pend.delete();
            act_m = '0; m_active = 0; age = 0;
            e_ready = 1; e_busy = 0; e_start = 0; e_den = 0;
            e_done = 0; e_err = 0; e_clr = 0; e_status = '0;
        end else begin
            push  = bus.req_valid_i && e_ready;
            ended = 0;
            fin   = '0;
            e_start = 0; e_clr = 0; e_err = 0;
            if (e_done) begin
                e_done = 0;
            end else if (m_active) begin
                if (abort) begin
                    ended = 1; fin = 16'h4000;
                end else if (age >= 2 && bus.eot_i) begin
                    ended = 1; fin = {2'b00, bus.status_i[13:0]};
                end else if (age >= 2 && tlim != 0 && (age - 2) == tlim) begin
                    ended = 1; fin = 16'h8000;
                end
                if (ended) begin
                    m_active = 0; e_done = 1; e_clr = 1; e_den = 0;
                    e_status = fin;
                    e_err = (fin[15:8] != 8'h00) || (fin[5:0] != 6'h00);
                end else begin
                    age++;
                    e_start = (age == 1);
                end
            end else if (pend.size() > 0) begin
                act_m = pend.pop_front();
                m_active = 1; age = 0;
                e_den = act_m.data_en;
            end
            if (push) pend.push_back(cur);
            e_ready = (pend.size() == 0);
            e_busy  = m_active || e_done;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cyc >= 1) begin
            chk("ctrl{rdy,busy,start,den,done,err,clr}",
                {bus.req_ready_o, busy, bus.cmd_start_o, bus.data_en_o, done, err, bus.clr_stat_o},
                {e_ready, e_busy, e_start, e_den, e_done, e_err, e_clr});
            chk("status", status, e_status);
            chk("fields",
                {bus.cmd_op_o, bus.cmd_arg_o, bus.cmd_rsp_type_o, bus.data_rwn_o,
                 bus.data_quad_o, bus.data_block_size_o, bus.data_block_num_o},
                {act_m.cmd_op, act_m.cmd_arg, act_m.rsp_type, act_m.data_rwn,
                 act_m.data_quad, act_m.block_size, act_m.block_num});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    function automatic sdio_req_t mk(input logic [5:0] op, input logic [31:0] arg,
                                     input logic [2:0] rsp, input logic den,
                                     input logic rwn, input logic quad,
                                     input logic [9:0] bs, input logic [7:0] bn);
        sdio_req_t r;
        r = '{cmd_op: op, cmd_arg: arg, rsp_type: rsp, data_en: den, data_rwn: rwn,
              data_quad: quad, block_size: bs, block_num: bn};
        return r;
    endfunction

    task automatic drive_req(input sdio_req_t r, input logic v);
        bus.req_valid_i      = v;
        bus.req_cmd_op_i     = r.cmd_op;
        bus.req_cmd_arg_i    = r.cmd_arg;
        bus.req_rsp_type_i   = r.rsp_type;
        bus.req_data_en_i    = r.data_en;
        bus.req_data_rwn_i   = r.data_rwn;
        bus.req_data_quad_i  = r.data_quad;
        bus.req_block_size_i = r.block_size;
        bus.req_block_num_i  = r.block_num;
    endtask

    // Returns the cycle in which the request was presented with ready high
    task automatic do_push(input sdio_req_t r, output int acc);
        int n;
        n = 0;
        while (!bus.req_ready_o && n < 50) begin
            tick(); n++;
        end
        chk("push_ready_wait", (n < 50), 1);
        drive_req(r, 1'b1);
        acc = cyc;
        tick();
        bus.req_valid_i = 1'b0;
    endtask

    task automatic wait_start(output int ts, output int den_at);
        int n;
        n = 0; ts = -1; den_at = -1;
        while (n < 100) begin
            if (bus.data_en_o && den_at < 0) den_at = cyc;
            if (bus.cmd_start_o) begin
                ts = cyc;
                break;
            end
            tick(); n++;
        end
        chk("start_seen", (ts >= 0), 1);
    endtask

    task automatic wait_done(input int bound, output int td);
        int n;
        n = 0; td = -1;
        while (n < bound) begin
            if (done) begin
                td = cyc;
                break;
            end
            tick(); n++;
        end
        chk("done_seen", (td >= 0), 1);
    endtask

    task automatic pulse_eot(input logic [15:0] st);
        bus.eot_i = 1'b1; bus.status_i = st;
        tick();
        bus.eot_i = 1'b0; bus.status_i = '0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        sdio_req_t ra, rb;
        int acc, acc_b, ts, den_at, td, dcnt;
        rst = 1'b1; abort = 1'b0;
        bus.eot_i = 1'b0; bus.status_i = '0;
        drive_req('0, 1'b0);
`ifdef SDIO_CMD_SEQ_TIMEOUT_EN
        tmo = '0;
`endif
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // reset state
        chk("rst_ready", bus.req_ready_o, 1);
        chk("rst_busy", busy, 0);
        chk("rst_status", status, 16'h0000);
        chk("rst_start_den", {bus.cmd_start_o, bus.data_en_o, done, err}, 4'b0000);

        // single read, op 17, eot with clean status
        ra = mk(6'd17, 32'h1234_5678, 3'd1, 1'b1, 1'b1, 1'b0, 10'd512, 8'd0);
        do_push(ra, acc);
        wait_start(ts, den_at);
        chk("accept_to_start", ts - acc, 3);
        chk("den_one_before_start", den_at, acc + 2);
        chk("start_op", bus.cmd_op_o, 17);
        tick();
        chk("start_one_cycle", bus.cmd_start_o, 0);
        repeat (19) tick();
        pulse_eot(16'h0000);
        chk("done_after_eot", done, 1);
        chk("clean_err", err, 0);
        chk("clean_status", status, 16'h0000);
        chk("clr_stat", bus.clr_stat_o, 1);
        tick();
        chk("done_one_cycle", done, 0);
        chk("den_low_after", bus.data_en_o, 0);

        // data error status
        ra = mk(6'd53, 32'h0000_1000, 3'd5, 1'b1, 1'b0, 1'b1, 10'd64, 8'd3);
        do_push(ra, acc);
        wait_start(ts, den_at);
        repeat (3) tick();
        pulse_eot(16'h0200);
        chk("derr_done", done, 1);
        chk("derr_err", err, 1);
        chk("derr_status", status, 16'h0200);
        tick();

        // back-to-back requests
        ra = mk(6'd52, 32'hAAAA_0001, 3'd1, 1'b0, 1'b0, 1'b0, 10'd0, 8'd0);
        rb = mk(6'd53, 32'hBBBB_0002, 3'd5, 1'b1, 1'b1, 1'b1, 10'd256, 8'd7);
        do_push(ra, acc);
        do_push(rb, acc_b);
        chk("ready_low_after_2nd", bus.req_ready_o, 0);
        repeat (5) tick();
        pulse_eot(16'h0000);
        chk("b2b_first_done", done, 1);
        td = cyc;
        wait_start(ts, den_at);
        chk("b2b_done_to_start", ts - td, 3);
        chk("b2b_op", bus.cmd_op_o, 53);
        chk("b2b_arg", bus.cmd_arg_o, 32'hBBBB_0002);
        chk("b2b_bnum", bus.data_block_num_o, 7);
        repeat (3) tick();
        pulse_eot(16'h0000);
        tick();

        // abort two cycles into the wait
        ra = mk(6'd7, 32'h0, 3'd2, 1'b1, 1'b1, 1'b0, 10'd32, 8'd1);
        do_push(ra, acc);
        wait_start(ts, den_at);
        repeat (2) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_done", done, 1);
        chk("abort_err", err, 1);
        chk("abort_status", status, 16'h4000);
        tick();
        pulse_eot(16'h0001);
        dcnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) dcnt++;
            tick();
        end
        chk("late_eot_ignored", dcnt, 0);

`ifdef SDIO_CMD_SEQ_TIMEOUT_EN
        // watchdog fires
        tmo = 16'd50;
        do_push(ra, acc);
        wait_start(ts, den_at);
        wait_done(100, td);
        chk("timeout_latency", td - ts, 52);
        chk("timeout_status", status, 16'h8000);
        chk("timeout_err", err, 1);
        tick();

        // watchdog disabled
        tmo = 16'd0;
        do_push(ra, acc);
        wait_start(ts, den_at);
        dcnt = 0;
        for (int i = 0; i < 1000; i++) begin
            if (done) dcnt++;
            tick();
        end
        chk("no_timeout_when_zero", dcnt, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
`endif

        // reset during the wait
        ra = mk(6'd24, 32'hDEAD_BEEF, 3'd1, 1'b1, 1'b0, 1'b1, 10'd512, 8'd15);
        do_push(ra, acc);
        wait_start(ts, den_at);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_ready", bus.req_ready_o, 1);
        chk("midrst_ctrl", {busy, done, err, bus.data_en_o, bus.cmd_start_o}, 5'b00000);
        chk("midrst_status", status, 16'h0000);
        chk("midrst_op", bus.cmd_op_o, 0);
        tick();

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            drive_req(mk(6'($urandom), $urandom, 3'($urandom), 1'($urandom), 1'($urandom),
                         1'($urandom), 10'($urandom), 8'($urandom)),
                      1'(($urandom % 3) == 0));
            bus.eot_i    = 1'(($urandom % 12) == 0);
            bus.status_i = (($urandom % 3) == 0) ? 16'h0000 : 16'($urandom);
            abort        = 1'(($urandom % 60) == 0);
            rst          = 1'(($urandom % 700) == 0);
`ifdef SDIO_CMD_SEQ_TIMEOUT_EN
            if (($urandom % 200) == 0) tmo = (($urandom % 3) == 0) ? 16'd0 : 16'($urandom_range(1, 30));
`endif
            tick();
        end
        drive_req('0, 1'b0);
        bus.eot_i = 1'b0; abort = 1'b0; rst = 1'b0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
